// File: rtl/clkdiv_pkg.sv
// Shared definitions for the clock-divider controller slice.
//   state_t             : controller FSM encoding (IDLE / RUN / DRAIN)
//   DIV_W_DEFAULT       : default width of the divide value and counter
//   DIV_DEFAULT_VALUE   : default divide value loaded at reset
package clkdiv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int          DIV_W_DEFAULT     = 32;
  localparam int unsigned DIV_DEFAULT_VALUE = 999999;

endpackage

// File: rtl/clkdiv_counter.sv
// Half-period counter with terminal-count detect and divided-clock toggle.
//   clk, rst    : system clock, synchronous active-high reset
//   en          : count (controller is RUN or DRAIN)
//   clr         : hold counter and divided_clk at 0 (controller is IDLE)
//   div         : terminal value; half-period is div+1 cycles
//   term        : combinational, high on the cycle the counter equals div
//   divided_clk : registered divided clock, toggles on each terminal edge
module clkdiv_counter #(
  parameter int DIV_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             term,
  output logic             divided_clk
);

  logic [DIV_W-1:0] count;

  // The counter is reset to 0 at every terminal edge and div never drops
  // below 1 mid-half-period, so equality is sufficient and no wrap occurs.
  assign term = en && (count == div);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count       <= '0;
      divided_clk <= 1'b0;
    end else if (en) begin
      if (term) begin
        count       <= '0;
        divided_clk <= ~divided_clk;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/clkdiv_controller.sv
// Run/stop and glitch-free reconfiguration controller for a divided clock.
//   clk, rst     : system clock, synchronous active-high reset
//   start, stop  : run request / drain-to-low request (stop wins)
//   cfg_valid    : new divide value offered on cfg_div
//   cfg_div      : new divide value (half-period = cfg_div+1 cycles)
//   cfg_ready    : config can be accepted (no shadow value pending)
//   cfg_err      : one-cycle pulse, a zero divide value was rejected
//   divided_clk  : registered divided clock, parks low when stopped
//   tick         : one-cycle pulse coinciding with each divided_clk toggle
//   running      : FSM is not IDLE
//   pending      : shadow value waiting for the next half-period boundary
//   div_active   : divide value currently in use
module clkdiv_controller
  import clkdiv_pkg::*;
#(
  parameter int          DIV_W       = DIV_W_DEFAULT,
  parameter int unsigned DIV_DEFAULT = DIV_DEFAULT_VALUE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             divided_clk,
  output logic             tick,
  output logic             running,
  output logic             pending,
  output logic [DIV_W-1:0] div_active
);

  state_t           state, state_nx;
  logic [DIV_W-1:0] shadow;
  logic             term;
  logic             accept;

  assign cfg_ready = ~pending;
  assign accept    = cfg_valid && cfg_ready;
  assign running   = (state != IDLE);

  clkdiv_counter #(.DIV_W(DIV_W)) u_counter (
    .clk         (clk),
    .rst         (rst),
    .en          (state != IDLE),
    .clr         (state == IDLE),
    .div         (div_active),
    .term        (term),
    .divided_clk (divided_clk)
  );

  // NOTE: the next state is defaulted before the case so every path assigns
  // it and no latch is inferred.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (start && !stop) state_nx = RUN;
      RUN:   if (stop) state_nx = DRAIN;
      // A fresh run request keeps the clock going; otherwise leave only on
      // the terminal edge that brings divided_clk low.
      DRAIN: if (start && !stop)       state_nx = RUN;
             else if (term && divided_clk) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tick       <= 1'b0;
      cfg_err    <= 1'b0;
      pending    <= 1'b0;
      shadow     <= '0;
      div_active <= DIV_W'(DIV_DEFAULT);
    end else begin
      state   <= state_nx;
      tick    <= term;
      cfg_err <= 1'b0;

      // The old div_active decides this terminal edge; the shadow governs
      // the next half-period.
      if (term && pending) begin
        div_active <= shadow;
        pending    <= 1'b0;
      end

      // accept needs pending==0, so it never collides with the apply above.
      if (accept) begin
        if (cfg_div == '0) begin
          cfg_err <= 1'b1;
        end else if (state == IDLE) begin
          div_active <= cfg_div;
        end else begin
          shadow  <= cfg_div;
          pending <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/clkdiv_controller.md
Name: clkdiv_controller

Overview:
Run/stop and reconfiguration controller wrapped around a programmable clock-divider counter. It accepts new divide values over a valid/ready config port. New values are applied only at a half-period boundary, so `divided_clk` never glitches. Stop drains cleanly so `divided_clk` always parks low. The block sits between the board-level control logic (buttons, UART command decoder) and LED/peripheral consumers of the slow clock and the per-half-period `tick`.

Parameters:
- DIV_W, 32, width of divide value and counter
- DIV_DEFAULT, 999999, divide value loaded at reset (half-period = DIV_DEFAULT+1 cycles)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse/level; request RUN
- stop  in  1  pulse/level; request stop (drain to low)
- cfg_valid  in  1  new divide value offered
- cfg_div  in  DIV_W  new divide value (half-period = cfg_div+1 cycles)
- cfg_ready  out  1  config can be accepted
- cfg_err  out  1  one-cycle pulse: cfg_div==0 was rejected
- divided_clk  out  1  divided clock, registered
- tick  out  1  one-cycle pulse on every divided_clk toggle
- running  out  1  state != IDLE
- pending  out  1  shadow value waiting for boundary
- div_active  out  DIV_W  divide value currently in use

Behaviour:
- Interface (already decided): one clock `clk`; `rst` synchronous, active-high.
- Reset: state=IDLE, counter=0, divided_clk=0, tick=0, cfg_err=0, pending=0, div_active=DIV_DEFAULT, cfg_ready=1.
- FSM states: IDLE, RUN, DRAIN.
- IDLE: counter held at 0, divided_clk=0, no ticks.
  - start=1 -> RUN; counter<=0.
  - stop has no effect.
- RUN: counter increments each cycle.
  - Terminal edge is counter==div_active: counter<=0, divided_clk<=~divided_clk, tick<=1 (tick is registered and coincides with the new divided_clk level).
  - First tick appears div_active+1 cycles after the start edge. Tick period is div_active+1; divided_clk period is 2*(div_active+1).
  - stop=1 -> DRAIN. Counting continues uninterrupted.
- DRAIN: counting and ticking as in RUN.
  - At a terminal edge, if the new divided_clk is 0 -> IDLE; otherwise stay in DRAIN.
  - start=1 and stop=0 -> back to RUN, no counter disturbance.
- Simultaneous start and stop: stop wins.
  - In IDLE this is a no-op.
  - In RUN the FSM goes to DRAIN.
- Config handshake: transfer occurs when cfg_valid && cfg_ready. cfg_ready = ~pending.
  - cfg_div==0: dropped; cfg_err pulses for 1 cycle; no state change.
  - IDLE: div_active<=cfg_div on the accept edge; pending stays 0.
  - RUN/DRAIN: shadow<=cfg_div, pending<=1.
  - At the next terminal edge: div_active<=shadow, pending<=0. The old div_active decides that terminal edge; the new value governs the following half-period.
  - Accept on a terminal edge with pending=0: the value becomes pending and is applied at the next terminal edge, not the current one.
- Pending shadow when the FSM reaches IDLE via drain: applied on the same final terminal edge, as normal.
- Wrap/width: counter is DIV_W bits. It never exceeds div_active, so there is no overflow. The comparison is equality only.
- rst mid-operation: everything returns to reset values next cycle, including div_active=DIV_DEFAULT. Any pending shadow is discarded.

Decomposition:
- Package clkdiv_pkg:
  - state encodings IDLE=2'd0, RUN=2'd1, DRAIN=2'd2
  - DIV_W default
  - DIV_DEFAULT default
- One sub-module, clkdiv_counter, containing:
  - counter
  - terminal-count detect
  - divided_clk toggle register
  - inputs: clk, rst, en, clr, div
  - outputs: term, divided_clk
- FSM, shadow register and handshake live in clkdiv_controller.

Test Plan:
- Reset with DIV_DEFAULT overridden to 3, start pulse at cycle 0 -> ticks at cycles 4, 8, 12; divided_clk high cycles 4-7, low 8-11; running=1 from cycle 1.
- Running at div 3, cfg_div=1 offered at cycle 5 -> accepted (cfg_ready 1->0, pending=1); ticks at 8 (old period), then 10, 12; pending clears and div_active=1 at cycle 8.
- Second cfg offered while pending=1 -> cfg_ready=0, not accepted until the boundary; the value is held by the bench and accepted on the first cycle after pending clears.
- Stop while divided_clk=1 (div 3) -> one more tick, divided_clk falls, IDLE. Stop while divided_clk=0 -> two more ticks, ends low; running falls with the final tick.
- cfg_div=0 in IDLE and in RUN -> cfg_err 1-cycle pulse, div_active unchanged, pending stays 0. Start+stop simultaneously in RUN -> DRAIN.
- rst asserted mid-half-period with pending=1 -> next cycle divided_clk=0, tick=0, pending=0, div_active=DIV_DEFAULT, state IDLE; a subsequent start restarts from counter 0.
